csa_pipe_addsub: RTL and testbench

- Parametrised, pipelined carry-select adder/subtractor. Successor to the fixed 32-bit, 8-bit-block combinational carry-select adder.
- Splits WIDTH into NBLK = WIDTH/BLK blocks and resolves one block per pipeline stage, using a dual-sum (carry 0 / carry 1) select.
- Adds subtract mode, borrow chaining, signed overflow and a valid/ready handshake, so it can sit between registered datapath stages.

---
 rtl/csa_pipe_addsub.sv | 160 ++++++++++++++++
 tb/tb_csa_pipe_addsub.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_pipe_addsub.sv
`timescale 1ns/1ps
// csa_pipe_addsub: pipelined carry-select adder/subtractor.
//
// The WIDTH-bit operation is split into NBLK = WIDTH/BLK blocks. Each clock,
// one block is resolved: both block sums (carry-in 0 and carry-in 1) are
// formed, and the real incoming carry picks one. Block 0 works straight off
// the input ports. Block k works off stage register k. The result leaves
// from stage register NBLK, so the latency is exactly NBLK cycles.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready = !out_valid | out_ready)
//   a, b, cin, sub      operands; sub=1 computes a + ~b + !cin
//   out_valid/out_ready output handshake; outputs hold while stalled
//   sum, cout, ovf      result mod 2^WIDTH, raw MSB carry, signed overflow

// One carry-select block. It produces both candidate sums and selects one
// by cin. c_msb is the carry into the block's top bit, recovered as
// a^b^s on that bit.
module csa_blk #(
    parameter int BLK = 8
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           cin,
    output logic [BLK-1:0] s,
    output logic           cout,
    output logic           c_msb
);
    logic [BLK:0] sum0, sum1, sel;

    assign sum0  = {1'b0, a} + {1'b0, b};
    assign sum1  = {1'b0, a} + {1'b0, b} + {{BLK{1'b0}}, 1'b1};
    assign sel   = cin ? sum1 : sum0;
    assign s     = sel[BLK-1:0];
    assign cout  = sel[BLK];
    assign c_msb = a[BLK-1] ^ b[BLK-1] ^ sel[BLK-1];
endmodule

module csa_pipe_addsub #(
    parameter int WIDTH = 32,
    parameter int BLK   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NBLK = WIDTH / BLK;

    if ((BLK < 1) || (WIDTH < BLK) || ((WIDTH % BLK) != 0)) begin : g_bad_param
        $fatal(1, "csa_pipe_addsub: WIDTH must be a positive multiple of BLK");
    end

    // Stage register k (1..NBLK) holds the state entering block k.
    // The operands are shifted down by BLK each stage, so the live block is
    // always bits [BLK-1:0]. Resolved sum bits are shifted in from the top,
    // so after NBLK stages they sit in their natural positions.
    logic [NBLK:1]    vld_q, vld_d;
    logic [NBLK:1]    c_q,   c_d;
    logic [WIDTH-1:0] s_q [1:NBLK];
    logic [WIDTH-1:0] s_d [1:NBLK];
    logic [WIDTH-1:0] a_q [1:NBLK];
    logic [WIDTH-1:0] a_d [1:NBLK];
    logic [WIDTH-1:0] b_q [1:NBLK];
    logic [WIDTH-1:0] b_d [1:NBLK];
    logic             ovf_q, ovf_d;

    // Block inputs (index = block number).
    logic [WIDTH-1:0] blk_a [NBLK];
    logic [WIDTH-1:0] blk_b [NBLK];
    logic [WIDTH-1:0] blk_s [NBLK];
    logic [NBLK-1:0]  blk_c, blk_v;
    // Block outputs.
    logic [BLK-1:0]   blk_sum [NBLK];
    logic [NBLK-1:0]  blk_co, blk_cm;

    logic advance;

    // A single global stall: the whole pipe moves only when the output slot
    // is empty or is being drained this cycle.
    assign advance  = !vld_q[NBLK] || out_ready;
    assign in_ready = advance;

    always_comb begin
        // Operand conditioning: subtract is a + ~b + 1, and the carry-in
        // is inverted so that cin=1 acts as a borrow.
        blk_a[0] = a;
        blk_b[0] = sub ? ~b : b;
        blk_c[0] = cin ^ sub;
        blk_s[0] = '0;
        blk_v[0] = in_valid;
        for (int k = 1; k < NBLK; k++) begin
            blk_a[k] = a_q[k];
            blk_b[k] = b_q[k];
            blk_c[k] = c_q[k];
            blk_s[k] = s_q[k];
            blk_v[k] = vld_q[k];
        end
    end

    for (genvar k = 0; k < NBLK; k++) begin : g_blk
        csa_blk #(.BLK(BLK)) u_blk (
            .a     (blk_a[k][BLK-1:0]),
            .b     (blk_b[k][BLK-1:0]),
            .cin   (blk_c[k]),
            .s     (blk_sum[k]),
            .cout  (blk_co[k]),
            .c_msb (blk_cm[k])
        );
    end

    always_comb begin
        for (int k = 0; k < NBLK; k++) begin
            vld_d[k+1] = blk_v[k];
            c_d[k+1]   = blk_co[k];
            s_d[k+1]   = (blk_s[k] >> BLK) | (WIDTH'(blk_sum[k]) << (WIDTH - BLK));
            a_d[k+1]   = blk_a[k] >> BLK;
            b_d[k+1]   = blk_b[k] >> BLK;
        end
        // Overflow: the carry into the MSB differs from the carry out of it.
        ovf_d = blk_cm[NBLK-1] ^ blk_co[NBLK-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int k = 1; k <= NBLK; k++) begin
                s_q[k] <= '0;
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
        end else if (advance) begin
            vld_q <= vld_d;
            c_q   <= c_d;
            ovf_q <= ovf_d;
            for (int k = 1; k <= NBLK; k++) begin
                s_q[k] <= s_d[k];
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
            end
        end
    end

    assign out_valid = vld_q[NBLK];
    assign sum       = s_q[NBLK];
    assign cout      = c_q[NBLK];
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_csa_pipe_addsub.sv
`timescale 1ns/1ps
// Testbench for csa_pipe_addsub: directed table, streaming with stall,
// mid-flight reset on a 32/8 instance, plus random sweeps on 16/16 and 64/8.
module tb_csa_pipe_addsub;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, got, exp);
        end
    endtask

    // Reference: plain wide arithmetic on w-bit operands.
    function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                  input logic cin, input logic sub, input int w,
                                  output logic [63:0] s, output logic co, output logic ov);
        logic [64:0] mask, av, bv, full;
        mask = (65'd1 << w) - 65'd1;
        av   = {1'b0, a} & mask;
        bv   = {1'b0, (sub ? ~b : b)} & mask;
        full = av + bv + 65'(cin ^ sub);
        s    = full[63:0] & mask[63:0];
        co   = full[w];
        ov   = (av[w-1] == bv[w-1]) && (s[w-1] != av[w-1]);
    endfunction

    // ---------------- main 32/8 instance ----------------
    logic        m_rst, m_in_valid, m_in_ready, m_cin, m_sub;
    logic        m_out_valid, m_out_ready, m_cout, m_ovf;
    logic [31:0] m_a, m_b, m_sum;

    csa_pipe_addsub #(.WIDTH(32), .BLK(8)) u_dut (
        .clk       (clk),
        .rst       (m_rst),
        .in_valid  (m_in_valid),
        .in_ready  (m_in_ready),
        .a         (m_a),
        .b         (m_b),
        .cin       (m_cin),
        .sub       (m_sub),
        .out_valid (m_out_valid),
        .out_ready (m_out_ready),
        .sum       (m_sum),
        .cout      (m_cout),
        .ovf       (m_ovf)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] exp_sum;
        logic        exp_cout;
        logic        exp_ovf;
    } vec_t;

    // Issue one op into an empty pipe and wait (bounded) for its result.
    task automatic run_one(input logic [31:0] ta, input logic [31:0] tb_, input logic tc,
                           input logic ts, output logic [31:0] rs, output logic rco,
                           output logic rov, output int lat, output bit ok);
        int start;
        @(negedge clk);
        m_a = ta; m_b = tb_; m_cin = tc; m_sub = ts; m_in_valid = 1'b1;
        #1;
        start = cyc;
        @(negedge clk);
        m_in_valid = 1'b0;
        ok = 1'b0; rs = '0; rco = 1'b0; rov = 1'b0; lat = 0;
        for (int i = 0; i < 20; i++) begin
            if (m_out_valid) begin
                rs = m_sum; rco = m_cout; rov = m_ovf; lat = cyc - start; ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // ---------------- random sweeps on other geometries ----------------
    for (genvar g = 0; g < 2; g++) begin : g_sw
        localparam int W  = (g == 0) ? 16 : 64;
        localparam int B  = (g == 0) ? 16 : 8;
        localparam int NB = W / B;

        logic         rst, iv, ir, ov, ordy, cin, sub, co, ovf;
        logic [W-1:0] a, b, s;
        bit           done = 1'b0;

        csa_pipe_addsub #(.WIDTH(W), .BLK(B)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (iv),
            .in_ready  (ir),
            .a         (a),
            .b         (b),
            .cin       (cin),
            .sub       (sub),
            .out_valid (ov),
            .out_ready (ordy),
            .sum       (s),
            .cout      (co),
            .ovf       (ovf)
        );

        logic [63:0] q_s [$];
        logic        q_co [$];
        logic        q_ov [$];
        int          q_c [$];

        initial begin
            int          sent, recv;
            logic [63:0] es;
            logic        eco, eov;
            sent = 0; recv = 0;
            rst = 1'b1; iv = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; ordy = 1'b1;
            repeat (2) @(negedge clk);
            rst = 1'b0;
            for (int t = 0; t < 5000 && (sent < 1000 || recv < sent); t++) begin
                @(negedge clk);
                if (sent < 1000 && $urandom_range(0, 3) != 0) begin
                    iv  = 1'b1;
                    a   = W'({$urandom(), $urandom()});
                    b   = W'({$urandom(), $urandom()});
                    cin = 1'($urandom());
                    sub = 1'($urandom());
                end else begin
                    iv = 1'b0;
                end
                #1;
                if (ov) begin
                    if (q_s.size() == 0) begin
                        chk($sformatf("w%0d_extra_out", W), 1, 0);
                    end else begin
                        chk($sformatf("w%0d_sum", W), 64'(s), q_s.pop_front());
                        chk($sformatf("w%0d_cout", W), 64'(co), 64'(q_co.pop_front()));
                        chk($sformatf("w%0d_ovf", W), 64'(ovf), 64'(q_ov.pop_front()));
                        chk($sformatf("w%0d_latency", W), 64'(cyc - q_c.pop_front()), 64'(NB));
                    end
                    recv++;
                end
                if (iv && ir) begin
                    model(64'(a), 64'(b), cin, sub, W, es, eco, eov);
                    q_s.push_back(es); q_co.push_back(eco); q_ov.push_back(eov);
                    q_c.push_back(cyc);
                    sent++;
                end
            end
            iv = 1'b0;
            chk($sformatf("w%0d_count", W), 64'(recv), 64'd1000);
            done = 1'b1;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        vec_t        tbl [8];
        logic [31:0] rs;
        logic        rco, rov, ok;
        int          lat;
        logic [31:0] sa [8], sb [8];
        logic        sc [8], ss [8];
        logic [63:0] es, q_s [$];
        logic        eco, eov, q_co [$], q_ov [$];
        int          idx, got, spurious;
        bit          held;
        logic [31:0] h_sum;
        logic        h_co, h_ov;

        tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        tbl[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        tbl[2] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        tbl[3] = '{32'h0000_0010, 32'h0000_0001, 1'b1, 1'b1, 32'h0000_000E, 1'b1, 1'b0};
        tbl[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        tbl[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        tbl[6] = '{32'h1234_5678, 32'h0000_FFFF, 1'b1, 1'b0, 32'h1235_5678, 1'b0, 1'b0};
        tbl[7] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};

        m_rst = 1'b1; m_in_valid = 1'b0; m_a = '0; m_b = '0; m_cin = 1'b0; m_sub = 1'b0;
        m_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(m_out_valid), 0);
        chk("rst_sum", 64'(m_sum), 0);
        chk("rst_cout", 64'(m_cout), 0);
        chk("rst_ovf", 64'(m_ovf), 0);
        chk("rst_in_ready", 64'(m_in_ready), 1);
        m_rst = 1'b0;

        // Directed vectors.
        for (int i = 0; i < 8; i++) begin
            run_one(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, rs, rco, rov, lat, ok);
            if (!ok) chk($sformatf("vec%0d_timeout", i), 0, 1);
            else begin
                chk($sformatf("vec%0d_sum", i), 64'(rs), 64'(tbl[i].exp_sum));
                chk($sformatf("vec%0d_cout", i), 64'(rco), 64'(tbl[i].exp_cout));
                chk($sformatf("vec%0d_ovf", i), 64'(rov), 64'(tbl[i].exp_ovf));
                chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
            end
        end

        // Streaming: 8 back-to-back ops with a 3-cycle output stall.
        for (int i = 0; i < 8; i++) begin
            sa[i] = $urandom(); sb[i] = $urandom();
            sc[i] = 1'($urandom()); ss[i] = 1'($urandom());
        end
        idx = 0; got = 0; held = 1'b0; h_sum = '0; h_co = 1'b0; h_ov = 1'b0;
        for (int t = 0; t < 60 && got < 8; t++) begin
            @(negedge clk);
            m_out_ready = !(t >= 5 && t <= 7);
            if (idx < 8) begin
                m_a = sa[idx]; m_b = sb[idx]; m_cin = sc[idx]; m_sub = ss[idx];
                m_in_valid = 1'b1;
            end else begin
                m_in_valid = 1'b0;
            end
            #1;
            if (m_out_valid && !m_out_ready) begin
                chk("hold_in_ready", 64'(m_in_ready), 0);
                if (!held) begin
                    h_sum = m_sum; h_co = m_cout; h_ov = m_ovf; held = 1'b1;
                end else begin
                    chk("hold_sum", 64'(m_sum), 64'(h_sum));
                    chk("hold_cout", 64'(m_cout), 64'(h_co));
                    chk("hold_ovf", 64'(m_ovf), 64'(h_ov));
                end
            end
            if (m_out_valid && m_out_ready) begin
                if (q_s.size() == 0) chk("stream_extra_out", 1, 0);
                else begin
                    chk($sformatf("stream%0d_sum", got), 64'(m_sum), q_s.pop_front());
                    chk($sformatf("stream%0d_cout", got), 64'(m_cout), 64'(q_co.pop_front()));
                    chk($sformatf("stream%0d_ovf", got), 64'(m_ovf), 64'(q_ov.pop_front()));
                end
                got++;
            end
            if (m_in_valid && m_in_ready) begin
                model(64'(m_a), 64'(m_b), m_cin, m_sub, 32, es, eco, eov);
                q_s.push_back(es); q_co.push_back(eco); q_ov.push_back(eov);
                idx++;
            end
        end
        m_in_valid = 1'b0; m_out_ready = 1'b1;
        chk("stream_held_seen", 64'(held), 1);
        chk("stream_sent", 64'(idx), 8);
        chk("stream_recv", 64'(got), 8);

        // Reset while three ops are in flight; the third collides with reset.
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            m_a = 32'h100 + i; m_b = 32'h1; m_cin = 1'b0; m_sub = 1'b0; m_in_valid = 1'b1;
            if (i == 2) m_rst = 1'b1;
            @(negedge clk);
        end
        m_rst = 1'b0; m_in_valid = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(m_out_valid), 0);
        chk("midrst_sum", 64'(m_sum), 0);
        spurious = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_out_valid) spurious++;
        end
        chk("midrst_spurious", 64'(spurious), 0);
        run_one(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, rs, rco, rov, lat, ok);
        if (!ok) chk("postrst_timeout", 0, 1);
        else begin
            chk("postrst_sum", 64'(rs), 64'd3);
            chk("postrst_latency", 64'(lat), 64'd4);
        end

        for (int i = 0; i < 20000 && !(g_sw[0].done && g_sw[1].done); i++) @(negedge clk);
        if (!(g_sw[0].done && g_sw[1].done)) chk("sweep_timeout", 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
